hvpp_sequencer: RTL

- Clocked, parametrised high-voltage parallel-programming sequencer for AVR-class DUTs (Mega8/Mega88 family and larger).
- Replaces host-driven, one-register-write-per-pin toggling with a per-command engine.
- The host issues one command: load command, load address, load data, PAGEL, write or read. The FSM drives XA/BS/data setup, strobe pulse, hold, RDY polling with timeout, and data sampling, then returns a one-cycle response.
- Sits between the bus-decode layer of a chip bottomhalf and its ZIF pin buffers. VCC/VPP control stays outside this block.

---
 rtl/hvpp_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/hvpp_sequencer.sv
// hvpp_sequencer: per-command high-voltage parallel-programming engine.
// One host command becomes a full selects/data setup, strobe, hold and
// (for WRITE) RDY wait sequence, finished by a one-clock response pulse.
// Cycle index 0 is the accepting edge. Index k is the interval between
// edge k-1 and edge k, so every output is registered on the edge that
// enters the state the output belongs to.
module hvpp_sequencer #(
    parameter int DATA_W       = 8,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int RDY_MASK_CYC = 4,
    parameter int TMO_W        = 24,
    parameter int TIMEOUT_CYC  = 240000
) (
    input  logic              osc_in,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_bs,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              dut_xtal,
    output logic              dut_pagel,
    output logic              dut_wr_n,
    output logic              dut_oe_n,
    output logic              dut_xa0,
    output logic              dut_xa1,
    output logic              dut_bs1,
    output logic              dut_bs2,
    output logic [DATA_W-1:0] dut_dout,
    output logic              dut_doe,
    input  logic [DATA_W-1:0] dut_din,
    input  logic              dut_rdy
);

    localparam logic [2:0] OP_LOAD_CMD  = 3'd0;
    localparam logic [2:0] OP_LOAD_ADDR = 3'd1;
    localparam logic [2:0] OP_LOAD_DATA = 3'd2;
    localparam logic [2:0] OP_PAGEL     = 3'd3;
    localparam logic [2:0] OP_WRITE     = 3'd4;
    localparam logic [2:0] OP_READ      = 3'd5;

    // Terminal counts: a phase of N clocks ends on the edge where cnt == N-1.
    localparam logic [TMO_W-1:0] SETUP_LAST = TMO_W'(SETUP_CYC - 1);
    localparam logic [TMO_W-1:0] PULSE_LAST = TMO_W'(PULSE_CYC - 1);
    localparam logic [TMO_W-1:0] MASK_LAST  = TMO_W'(RDY_MASK_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] CNT_ONE    = {{(TMO_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_PULSE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RDY_MASK = 3'd4,
        ST_WAIT_RDY = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t           state_r;
    logic [2:0]       op_r;
    logic [TMO_W-1:0] cnt_r;
    logic             rdy_s1_r;
    logic             rdy_s2_r;

    // Ops 6 and 7 are reserved and complete immediately with an error.
    function automatic logic is_reserved(input logic [2:0] op);
        return (op > OP_READ);
    endfunction

    // Bring the asynchronous RDY/BSY pin into the clock domain (2 flops).
    always_ff @(posedge osc_in or negedge rst_n) begin
        if (!rst_n) begin
            rdy_s1_r <= 1'b0;
            rdy_s2_r <= 1'b0;
        end else begin
            rdy_s1_r <= dut_rdy;
            rdy_s2_r <= rdy_s1_r;
        end
    end

    // Command sequencer: state, phase counter and all registered pin/response outputs.
    always_ff @(posedge osc_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= 3'd0;
            cnt_r     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            dut_xtal  <= 1'b0;
            dut_pagel <= 1'b0;
            dut_wr_n  <= 1'b1;
            dut_oe_n  <= 1'b1;
            dut_xa0   <= 1'b0;
            dut_xa1   <= 1'b0;
            dut_bs1   <= 1'b0;
            dut_bs2   <= 1'b0;
            dut_dout  <= '0;
            dut_doe   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r      <= cmd_op;
                        cnt_r     <= '0;
                        rsp_data  <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (is_reserved(cmd_op)) begin
                            // No pin activity at all; answer on the next edge.
                            state_r   <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_r <= ST_SETUP;
                            rsp_err <= 1'b0;
                            {dut_bs2, dut_bs1} <= cmd_bs;
                            case (cmd_op)
                                OP_LOAD_CMD: begin
                                    {dut_xa1, dut_xa0} <= 2'b10;
                                    dut_dout <= cmd_data;
                                    dut_doe  <= 1'b1;
                                end
                                OP_LOAD_ADDR: begin
                                    {dut_xa1, dut_xa0} <= 2'b00;
                                    dut_dout <= cmd_data;
                                    dut_doe  <= 1'b1;
                                end
                                OP_LOAD_DATA: begin
                                    {dut_xa1, dut_xa0} <= 2'b01;
                                    dut_dout <= cmd_data;
                                    dut_doe  <= 1'b1;
                                end
                                OP_READ: begin
                                    // Release the bus before OE can enable the DUT driver.
                                    dut_doe <= 1'b0;
                                end
                                default: begin
                                    // PAGEL and WRITE keep the previous selects and data.
                                end
                            endcase
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_PULSE;
                        case (op_r)
                            OP_LOAD_CMD, OP_LOAD_ADDR, OP_LOAD_DATA: dut_xtal  <= 1'b1;
                            OP_PAGEL: dut_pagel <= 1'b1;
                            OP_WRITE: dut_wr_n  <= 1'b0;
                            OP_READ:  dut_oe_n  <= 1'b0;
                            default: begin
                            end
                        endcase
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        cnt_r     <= '0;
                        state_r   <= ST_HOLD;
                        dut_xtal  <= 1'b0;
                        dut_pagel <= 1'b0;
                        dut_wr_n  <= 1'b1;
                        dut_oe_n  <= 1'b1;
                        // Sample on the last OE-low clock, data is settled by now.
                        if (op_r == OP_READ) begin
                            rsp_data <= dut_din;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    cnt_r <= '0;
                    if (op_r == OP_WRITE) begin
                        if (RDY_MASK_CYC > 0) begin
                            state_r <= ST_RDY_MASK;
                        end else begin
                            state_r <= ST_WAIT_RDY;
                        end
                    end else begin
                        state_r   <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_RDY_MASK: begin
                    // The DUT needs a few clocks to pull RDY low after WR; ignore it here.
                    if (cnt_r == MASK_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_WAIT_RDY;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_RDY: begin
                    if (rdy_s2_r) begin
                        state_r   <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end else if (cnt_r == TMO_LAST) begin
                        state_r   <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: return to a safe idle with strobes released.
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    dut_xtal  <= 1'b0;
                    dut_pagel <= 1'b0;
                    dut_wr_n  <= 1'b1;
                    dut_oe_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
